// File: rtl/tw_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single threewire master,
// with start and completion timeouts so a stuck transfer cannot hang a requester.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | no transfer owned; sample a_valid/b_valid and grant one
// WAIT_START | tw_start issued; waiting for tw_running to rise
// WAIT_DONE  | master running; waiting for tw_running to fall
// DRAIN      | completion timed out; wait for master to go idle before regranting
module tw_bus_arbiter #(
  parameter int ADDR_BITS     = 9,
  parameter int DATA_BITS     = 16,
  parameter int START_TIMEOUT = 8,
  parameter int DONE_TIMEOUT  = 1000,
  parameter int CNT_W         = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 a_valid,
  input  logic                 a_mode_wr,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [DATA_BITS-1:0] a_wr_data,
  output logic                 a_accept,
  output logic                 a_done,
  output logic                 a_err,
  output logic [DATA_BITS-1:0] a_rd_data,
  input  logic                 b_valid,
  input  logic                 b_mode_wr,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [DATA_BITS-1:0] b_wr_data,
  output logic                 b_accept,
  output logic                 b_done,
  output logic                 b_err,
  output logic [DATA_BITS-1:0] b_rd_data,
  output logic                 tw_start,
  output logic                 tw_mode_wr,
  output logic [ADDR_BITS-1:0] tw_addr,
  output logic [DATA_BITS-1:0] tw_wr_data,
  input  logic [DATA_BITS-1:0] tw_rd_data,
  input  logic                 tw_running,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, DRAIN} state_t;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST  = CNT_W'(DONE_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_b_q;
  logic             owner_b_q;
  logic             grant_a, grant_b;
  logic             fin, fin_err;
  logic             fin_a, fin_b;
  logic [DATA_BITS-1:0] fin_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state_q)
      IDLE: begin
        // on a tie, the requester that did not win last time goes first
        if (a_valid && (!b_valid || last_b_q)) begin
          grant_a = 1'b1;
        end else if (b_valid) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) begin
          state_d = WAIT_START;
          cnt_d   = '0;
        end
      end
      WAIT_START: begin
        if (tw_running) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (cnt_q >= START_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        // a fall on the expiry edge still counts as success
        if (!tw_running) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q >= DONE_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!tw_running) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fin_a    = fin && !owner_b_q;
  assign fin_b    = fin && owner_b_q;
  assign fin_data = (fin_err || tw_mode_wr) ? '0 : tw_rd_data;

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      owner_b_q  <= 1'b0;
      tw_start   <= 1'b0;
      tw_mode_wr <= 1'b0;
      tw_addr    <= '0;
      tw_wr_data <= '0;
      a_accept   <= 1'b0;
      a_done     <= 1'b0;
      a_err      <= 1'b0;
      a_rd_data  <= '0;
      b_accept   <= 1'b0;
      b_done     <= 1'b0;
      b_err      <= 1'b0;
      b_rd_data  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tw_start <= grant_a || grant_b;
      a_accept <= grant_a;
      b_accept <= grant_b;
      a_done   <= fin_a;
      b_done   <= fin_b;
      a_err    <= fin_a && fin_err;
      b_err    <= fin_b && fin_err;
      if (grant_a || grant_b) begin
        last_b_q   <= grant_b;
        owner_b_q  <= grant_b;
        tw_mode_wr <= grant_b ? b_mode_wr : a_mode_wr;
        tw_addr    <= grant_b ? b_addr    : a_addr;
        tw_wr_data <= grant_b ? b_wr_data : a_wr_data;
      end
      if (fin_a) begin
        a_rd_data <= fin_data;
      end
      if (fin_b) begin
        b_rd_data <= fin_data;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tw_bus_arbiter.sv
// Self-checking bench for tw_bus_arbiter: behavioural threewire master,
// grant/done scoreboards, a vector table and hand-written corner sequences.
module tb_tw_bus_arbiter;

  localparam int AB = 9;
  localparam int DB = 16;
  localparam int ST = 8;
  localparam int DT = 50;

  logic          in_clk = 1'b0;
  logic          in_rst = 1'b0;
  logic          a_valid = 1'b0, a_mode_wr = 1'b0;
  logic [AB-1:0] a_addr = '0;
  logic [DB-1:0] a_wr_data = '0;
  logic          b_valid = 1'b0, b_mode_wr = 1'b0;
  logic [AB-1:0] b_addr = '0;
  logic [DB-1:0] b_wr_data = '0;
  logic          a_accept, a_done, a_err, b_accept, b_done, b_err;
  logic [DB-1:0] a_rd_data, b_rd_data;
  logic          tw_start, tw_mode_wr, busy;
  logic [AB-1:0] tw_addr;
  logic [DB-1:0] tw_wr_data;
  logic [DB-1:0] tw_rd_data;
  logic          tw_running;

  tw_bus_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .START_TIMEOUT(ST),
    .DONE_TIMEOUT(DT), .CNT_W(16)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .a_valid(a_valid), .a_mode_wr(a_mode_wr), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_accept(a_accept), .a_done(a_done), .a_err(a_err), .a_rd_data(a_rd_data),
    .b_valid(b_valid), .b_mode_wr(b_mode_wr), .b_addr(b_addr), .b_wr_data(b_wr_data),
    .b_accept(b_accept), .b_done(b_done), .b_err(b_err), .b_rd_data(b_rd_data),
    .tw_start(tw_start), .tw_mode_wr(tw_mode_wr), .tw_addr(tw_addr),
    .tw_wr_data(tw_wr_data), .tw_rd_data(tw_rd_data), .tw_running(tw_running),
    .busy(busy)
  );

  always #5 in_clk = ~in_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // master model: run_len cycles of tw_running, read data presented at the fall
  bit            m_respond = 1'b1;
  int            m_run_len = 5;
  int            m_left = 0;
  logic [DB-1:0] m_rd_val = '0;

  initial begin
    tw_running = 1'b0;
    tw_rd_data = '0;
    forever begin
      @(posedge in_clk);
      #1;
      if (tw_start && m_respond) begin
        tw_running = 1'b1;
        m_left     = m_run_len;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          tw_running = 1'b0;
          tw_rd_data = m_rd_val;
        end
      end
    end
  end

  typedef struct {
    bit            is_b;
    bit            wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wd;
  } grant_t;

  typedef struct {
    bit            is_b;
    bit            err;
    logic [DB-1:0] rd;
  } done_t;

  grant_t gq[$];
  done_t  dq[$];
  bit     start_open = 1'b0;
  bit     tb_last_b  = 1'b1;

  task automatic issue(input bit is_b, input bit wr, input logic [AB-1:0] addr,
                       input logic [DB-1:0] wd, input bit err, input logic [DB-1:0] rd);
    grant_t g;
    done_t  d;
    g.is_b = is_b; g.wr = wr; g.addr = addr; g.wd = wd;
    d.is_b = is_b; d.err = err; d.rd = rd;
    gq.push_back(g);
    dq.push_back(d);
    if (is_b) begin
      b_mode_wr = wr; b_addr = addr; b_wr_data = wd; b_valid = 1'b1;
    end else begin
      a_mode_wr = wr; a_addr = addr; a_wr_data = wd; a_valid = 1'b1;
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  initial begin
    grant_t g;
    done_t  d;
    forever begin
      @(negedge in_clk);
      if (in_rst) begin
        if (a_accept || b_accept) begin
          if (gq.size() == 0) begin
            fail_now("unexpected_accept");
          end else begin
            g = gq.pop_front();
            chk("accept_owner", 32'({a_accept, b_accept}), g.is_b ? 32'h1 : 32'h2);
            chk("accept_start", 32'(tw_start), 32'h1);
            chk("tw_addr", 32'(tw_addr), 32'(g.addr));
            chk("tw_mode_wr", 32'(tw_mode_wr), 32'(g.wr));
            chk("tw_wr_data", 32'(tw_wr_data), 32'(g.wd));
          end
          if (a_accept) a_valid = 1'b0;
          if (b_accept) b_valid = 1'b0;
        end
        if (tw_start) begin
          chk("start_overlap", 32'(start_open), 32'h0);
          start_open = 1'b1;
        end
        if (a_done || b_done) begin
          start_open = 1'b0;
          if (dq.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            d = dq.pop_front();
            chk("done_owner", 32'({a_done, b_done}), d.is_b ? 32'h1 : 32'h2);
            chk("done_err", 32'(d.is_b ? b_err : a_err), 32'(d.err));
            chk("other_err", 32'(d.is_b ? a_err : b_err), 32'h0);
            chk("rd_data", 32'(d.is_b ? b_rd_data : a_rd_data), 32'(d.rd));
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge in_clk);
      n++;
    end while ((dq.size() != 0 || busy || a_valid || b_valid) && n < 500);
    if (n >= 500) fail_now({name, "_timeout"});
    @(negedge in_clk);
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    do begin
      @(negedge in_clk);
      n++;
    end while (!tw_start && n < 50);
    if (!tw_start) fail_now({name, "_no_start"});
  endtask

  task automatic check_zero(input string name);
    chk({name, "_flags"}, 32'({tw_start, a_accept, b_accept, a_done, b_done,
                                a_err, b_err, busy, tw_mode_wr}), 32'h0);
    chk({name, "_tw_addr"}, 32'(tw_addr), 32'h0);
    chk({name, "_tw_wr_data"}, 32'(tw_wr_data), 32'h0);
    chk({name, "_a_rd_data"}, 32'(a_rd_data), 32'h0);
    chk({name, "_b_rd_data"}, 32'(b_rd_data), 32'h0);
  endtask

  typedef struct {
    bit            is_b;
    bit            wr;
    logic [AB-1:0] addr;
    logic [DB-1:0] wd;
    bit            resp;
    int            run;
    logic [DB-1:0] rd;
    bit            exp_err;
    logic [DB-1:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  n;
    bit  drop, early, fell;
    vecs[0] = '{1'b0, 1'b0, 9'h1A5, 16'h0000, 1'b1, 20, 16'hBEEF, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 9'h003, 16'h0042, 1'b1,  5, 16'h9999, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 9'h0FF, 16'hAAAA, 1'b1,  3, 16'h1234, 1'b0, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 9'h1FF, 16'hFFFF, 1'b1,  1, 16'h4321, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 9'h000, 16'h0001, 1'b1,  7, 16'hA5A5, 1'b0, 16'hA5A5};
    vecs[5] = '{1'b0, 1'b0, 9'h155, 16'h0000, 1'b0,  0, 16'h7E7E, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 9'h0AA, 16'h0000, 1'b0,  0, 16'h6D6D, 1'b1, 16'h0000};

    repeat (3) @(negedge in_clk);
    check_zero("reset");
    in_rst = 1'b1;
    @(negedge in_clk);

    for (int i = 0; i < 7; i++) begin
      m_respond = vecs[i].resp;
      m_run_len = vecs[i].run;
      m_rd_val  = vecs[i].rd;
      issue(vecs[i].is_b, vecs[i].wr, vecs[i].addr, vecs[i].wd,
            vecs[i].exp_err, vecs[i].exp_rd);
      tb_last_b = vecs[i].is_b;
      wait_idle("vector");
    end

    // contention: both valid together; the requester not granted last goes first
    m_respond = 1'b1;
    m_run_len = 3;
    for (int r = 0; r < 3; r++) begin
      m_rd_val = 16'h0C00 + 16'(r);
      if (tb_last_b) begin
        issue(1'b0, 1'b0, 9'h010 + 9'(r), 16'h0000, 1'b0, 16'h0C00 + 16'(r));
        issue(1'b1, 1'b1, 9'h020 + 9'(r), 16'h5000 + 16'(r), 1'b0, 16'h0000);
        tb_last_b = 1'b1;
      end else begin
        issue(1'b1, 1'b1, 9'h020 + 9'(r), 16'h5000 + 16'(r), 1'b0, 16'h0000);
        issue(1'b0, 1'b0, 9'h010 + 9'(r), 16'h0000, 1'b0, 16'h0C00 + 16'(r));
        tb_last_b = 1'b0;
      end
      wait_idle("contention");
    end

    // start timeout: tw_start cycle counts as cycle 1, err done on cycle ST+1
    m_respond = 1'b0;
    issue(1'b0, 1'b0, 9'h0E1, 16'h0000, 1'b1, 16'h0000);
    tb_last_b = 1'b0;
    wait_start("start_to");
    n = 1;
    do begin
      @(negedge in_clk);
      n++;
    end while (!a_done && n < 40);
    chk("start_to_cycles", 32'(n), 32'(ST + 1));
    wait_idle("start_to");

    // done timeout: master holds running 80 cycles; B waits out the drain
    m_respond = 1'b1;
    m_run_len = 80;
    m_rd_val  = 16'h5555;
    issue(1'b0, 1'b0, 9'h0D0, 16'h0000, 1'b1, 16'h0000);
    wait_start("done_to");
    m_run_len = 4;
    m_rd_val  = 16'h7777;
    n = 1;
    do begin
      @(negedge in_clk);
      n++;
      if (n == 10) issue(1'b1, 1'b0, 9'h0B0, 16'h0000, 1'b0, 16'h7777);
    end while (!a_done && n < 200);
    chk("done_to_cycles", 32'(n), 32'(DT + 2));
    drop = 1'b0; early = 1'b0; fell = 1'b0;
    n = 0;
    do begin
      @(negedge in_clk);
      n++;
      if (!tw_running) fell = 1'b1;
      if (!fell && !busy) drop = 1'b1;
      if (b_accept && !fell) early = 1'b1;
    end while (!b_accept && n < 200);
    chk("drain_busy_drop", 32'(drop), 32'h0);
    chk("drain_early_grant", 32'(early), 32'h0);
    chk("drain_b_granted", 32'(b_accept), 32'h1);
    tb_last_b = 1'b1;
    wait_idle("done_to");

    // reset in WAIT_DONE: abandoned, no done, and A wins the next tie
    m_run_len = 30;
    m_rd_val  = 16'h1111;
    issue(1'b0, 1'b0, 9'h0C3, 16'h0000, 1'b0, 16'h1111);
    wait_start("rst_mid");
    repeat (5) @(negedge in_clk);
    in_rst = 1'b0;
    @(negedge in_clk);
    check_zero("rst_mid");
    dq.delete();
    gq.delete();
    start_open = 1'b0;
    in_rst = 1'b1;
    repeat (40) @(negedge in_clk);
    m_run_len = 3;
    m_rd_val  = 16'h2222;
    issue(1'b0, 1'b0, 9'h0C4, 16'h0000, 1'b0, 16'h2222);
    issue(1'b1, 1'b1, 9'h0C5, 16'h3333, 1'b0, 16'h0000);
    wait_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
